data_pack_n_to_word: RTL and testbench

Parametrised successor to the fixed 8-to-64 output packer. Collects N narrow beats (default N=8 bytes) from the UART receive path and assembles one wide word for the cipher core. Adds enable edge detection, selectable beat order, an inter-beat timeout that discards stale partial words, and a valid/ready output handshake with an overflow indication.

---
 rtl/data_pack_n_to_word.sv | 120 ++++++++++++
 tb/tb_data_pack_n_to_word.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_pack_n_to_word.sv
// Packs N_BEATS narrow beats, each taken on an enable rising edge, into one wide word.
// The word is offered on a valid/ready port. Stale partial words are dropped after an idle timeout.
module data_pack_n_to_word #(
   parameter int IN_W        = 8,
   parameter int N_BEATS     = 8,
   parameter int MSB_FIRST   = 1,
   parameter int TIMEOUT_CYC = 10000,
   localparam int OUT_W      = IN_W * N_BEATS,
   localparam int CW         = $clog2(N_BEATS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  data_in,
   input  logic             data_in_enable,
   output logic [OUT_W-1:0] data_out,
   output logic             data_out_valid,
   input  logic             data_out_ready,
   output logic [CW-1:0]    beat_cnt,
   output logic             overflow,
   output logic             timeout_flag
);

   logic             en_q;
   logic [OUT_W-1:0] asm_q;
   logic [OUT_W-1:0] asm_d;
   logic [CW-1:0]    slot;
   logic             capture;
   logic             last_beat;
   logic             complete;
   logic             fire;
   logic             blocked;
   logic             tmo_hit;

   assign capture   = data_in_enable & ~en_q;
   assign last_beat = (beat_cnt == CW'(N_BEATS - 1));
   assign complete  = capture & last_beat;
   assign fire      = data_out_valid & data_out_ready;
   assign blocked   = data_out_valid & ~data_out_ready;
   assign slot      = (MSB_FIRST != 0) ? CW'(N_BEATS - 1) - beat_cnt
                                       : beat_cnt;

   // Assembly word with the incoming beat merged into its slot
   always_comb begin
      asm_d = asm_q;
      for (int j = 0; j < N_BEATS; j++) begin
         if (slot == CW'(j)) begin
            asm_d[j*IN_W +: IN_W] = data_in;
         end
      end
   end

   // Enable history; resets high so a held enable is not a beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q <= 1'b1;
      end else begin
         en_q <= data_in_enable;
      end
   end

   // Beat counter and partial-word register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         asm_q    <= '0;
      end else if (capture) begin
         if (last_beat) begin
            beat_cnt <= '0;
            asm_q    <= '0;
         end else begin
            beat_cnt <= beat_cnt + CW'(1);
            asm_q    <= asm_d;
         end
      end else if (tmo_hit) begin
         beat_cnt <= '0;
         asm_q    <= '0;
      end
   end

   // Output word, handshake and event pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
         overflow       <= 1'b0;
         timeout_flag   <= 1'b0;
      end else begin
         overflow     <= complete & blocked;
         timeout_flag <= tmo_hit;
         if (complete && !blocked) begin
            data_out       <= asm_d;
            data_out_valid <= 1'b1;
         end else if (fire) begin
            data_out_valid <= 1'b0;
         end
      end
   end

   if (TIMEOUT_CYC > 0) begin : g_tmo
      localparam int TW = $clog2(TIMEOUT_CYC + 1);
      logic [TW-1:0] idle_q;

      assign tmo_hit = ~capture & (beat_cnt != '0)
                     & (idle_q == TW'(TIMEOUT_CYC - 1));

      // Idle cycles since the last beat of a partial word
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            idle_q <= '0;
         end else if (capture || tmo_hit || beat_cnt == '0) begin
            idle_q <= '0;
         end else begin
            idle_q <= idle_q + TW'(1);
         end
      end
   end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
   end

endmodule

// File: tb/tb_data_pack_n_to_word.sv
// Bench for data_pack_n_to_word: two instances (MSB-first with timeout, LSB-first without)
// checked every cycle against a beat-list reference model, plus directed word checks.
module tb_data_pack_n_to_word;

   logic        clk;
   logic        rst_n;
   logic [7:0]  din;
   logic        en;
   logic        rdy;

   logic [63:0] dout_a, dout_b;
   logic        vld_a, vld_b;
   logic [3:0]  bc_a, bc_b;
   logic        ovf_a, ovf_b;
   logic        tf_a, tf_b;

   int chk_cnt = 0;
   int err_cnt = 0;
   bit chk_on  = 0;
   bit rnd_rdy = 0;

   data_pack_n_to_word #(
      .IN_W(8), .N_BEATS(8), .MSB_FIRST(1), .TIMEOUT_CYC(10000)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_enable(en),
      .data_out(dout_a), .data_out_valid(vld_a), .data_out_ready(rdy),
      .beat_cnt(bc_a), .overflow(ovf_a), .timeout_flag(tf_a)
   );

   data_pack_n_to_word #(
      .IN_W(8), .N_BEATS(8), .MSB_FIRST(0), .TIMEOUT_CYC(0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_enable(en),
      .data_out(dout_b), .data_out_valid(vld_b), .data_out_ready(rdy),
      .beat_cnt(bc_b), .overflow(ovf_b), .timeout_flag(tf_b)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: list of received beats per instance
   logic [7:0]  m_b [2][8];
   int          m_cnt   [2];
   int          m_since [2];
   logic        m_prev  [2];
   logic [63:0] m_dout  [2];
   logic        m_vld   [2];
   logic        m_ovf   [2];
   logic        m_tf    [2];

   function automatic int tmo_of(int i);
      return (i == 0) ? 10000 : 0;
   endfunction

   function automatic logic [63:0] pack(int i);
      logic [63:0] w;
      int          s;
      w = '0;
      for (int k = 0; k < 8; k++) begin
         s = (i == 0) ? 7 - k : k;
         w = w | (64'(m_b[i][k]) << (8 * s));
      end
      return w;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic cap;
      logic vld0;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_cnt[i] = 0; m_since[i] = 0; m_prev[i] = 1'b1;
            m_dout[i] = '0; m_vld[i] = 1'b0;
            m_ovf[i] = 1'b0; m_tf[i] = 1'b0;
         end else begin
            cap = en && !m_prev[i];
            m_prev[i] = en;
            m_ovf[i] = 1'b0;
            m_tf[i] = 1'b0;
            vld0 = m_vld[i];
            if (vld0 && rdy) m_vld[i] = 1'b0;
            if (cap) begin
               m_b[i][m_cnt[i]] = din;
               m_cnt[i]++;
               m_since[i] = 0;
               if (m_cnt[i] == 8) begin
                  m_cnt[i] = 0;
                  if (vld0 && !rdy) begin
                     m_ovf[i] = 1'b1;
                  end else begin
                     m_dout[i] = pack(i);
                     m_vld[i] = 1'b1;
                  end
               end
            end else if (m_cnt[i] != 0 && tmo_of(i) > 0) begin
               m_since[i]++;
               if (m_since[i] == tmo_of(i)) begin
                  m_cnt[i] = 0;
                  m_since[i] = 0;
                  m_tf[i] = 1'b1;
               end
            end
         end
      end
   end

   int ovf_n [2] = '{0, 0};
   int tf_n  [2] = '{0, 0};
   int vld_n [2] = '{0, 0};

   always @(negedge clk) begin
      if (chk_on) begin
         check("a_dout", dout_a, m_dout[0]);
         check("a_vld",  vld_a,  m_vld[0]);
         check("a_cnt",  bc_a,   m_cnt[0]);
         check("a_ovf",  ovf_a,  m_ovf[0]);
         check("a_tmo",  tf_a,   m_tf[0]);
         check("b_dout", dout_b, m_dout[1]);
         check("b_vld",  vld_b,  m_vld[1]);
         check("b_cnt",  bc_b,   m_cnt[1]);
         check("b_ovf",  ovf_b,  m_ovf[1]);
         check("b_tmo",  tf_b,   m_tf[1]);
      end
      if (ovf_a) ovf_n[0]++;
      if (ovf_b) ovf_n[1]++;
      if (tf_a)  tf_n[0]++;
      if (tf_b)  tf_n[1]++;
      if (vld_a) vld_n[0]++;
      if (vld_b) vld_n[1]++;
   end

   task automatic tick(int n);
      repeat (n) begin
         @(negedge clk);
         if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
      end
   endtask

   // One beat: enable high for hi cycles, low for lo cycles
   task automatic beat(logic [7:0] d, int hi, int lo);
      din = d;
      en  = 1'b1;
      for (int c = 0; c < hi; c++) begin
         tick(1);
         din = 8'($urandom);
      end
      en = 1'b0;
      tick(lo);
   endtask

   logic [7:0] w1 [8] = '{8'hd7, 8'ha7, 8'h01, 8'ha0, 8'hc4, 8'h04, 8'h27, 8'hcb};
   logic [7:0] wa [8] = '{8'h46, 8'h4d, 8'h74, 8'h9a, 8'hfa, 8'h03, 8'h74, 8'h23};
   logic [7:0] wn [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   logic [7:0] wd [8] = '{8'ha1, 8'hb2, 8'hc3, 8'hd4, 8'he5, 8'hf6, 8'h07, 8'h18};
   logic [7:0] we [8] = '{8'h0f, 8'h1e, 8'h2d, 8'h3c, 8'h4b, 8'h5a, 8'h69, 8'h78};

   int base;
   int base2;

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      din   = 8'h00;
      rdy   = 1'b1;
      tick(3);
      check("rst_dout", dout_a, 64'h0);
      check("rst_vld",  vld_a,  1'b0);
      check("rst_cnt",  bc_a,   4'd0);
      #2 rst_n = 1'b1;
      tick(1);
      chk_on = 1;

      // MSB-first and LSB-first packing, 2-cycle pulses 4340 apart
      base  = vld_n[0];
      base2 = ovf_n[0] + tf_n[0];
      for (int k = 0; k < 8; k++) beat(w1[k], 2, 4338);
      check("t1_dout", dout_a, 64'hd7a701a0c40427cb);
      check("t2_dout", dout_b, 64'hcb2704c4a001a7d7);
      check("t1_vld_cycles", vld_n[0] - base, 1);
      check("t1_events", ovf_n[0] + tf_n[0] - base2, 0);

      // Consumer stalled: second word overflows
      rdy  = 1'b0;
      base = ovf_n[0];
      for (int k = 0; k < 8; k++) beat(wa[k], 2, 3);
      for (int k = 0; k < 8; k++) beat(8'($urandom), 2, 3);
      check("t3_dout", dout_a, 64'h464d749afa037423);
      check("t3_dout_b", dout_b, 64'h237403fa9a744d46);
      check("t3_vld", vld_a, 1'b1);
      check("t3_ovf_n", ovf_n[0] - base, 1);
      rdy = 1'b1;
      tick(1);
      check("t3_vld_clr", vld_a, 1'b0);

      // Long enable pulses give one beat each
      for (int k = 0; k < 8; k++) begin
         beat(8'($urandom), 20, 2);
         check("t5_cnt", bc_a, 4'((k + 1) % 8));
      end

      // Enable held through reset release
      en = 1'b1;
      #2 rst_n = 1'b0;
      tick(2);
      #2 rst_n = 1'b1;
      tick(3);
      check("t5_held_en", bc_a, 4'd0);
      en = 1'b0;
      tick(1);
      beat(8'h5c, 1, 1);
      check("t5_retoggle", bc_a, 4'd1);

      // Reset mid-word
      for (int k = 0; k < 5; k++) beat(8'($urandom), 2, 2);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_dout", dout_a, 64'h0);
      check("t6_rst_vld",  vld_a,  1'b0);
      check("t6_rst_cnt",  bc_a,   4'd0);
      check("t6_rst_ovf",  ovf_a,  1'b0);
      check("t6_rst_tmo",  tf_a,   1'b0);
      tick(2);
      #2 rst_n = 1'b1;
      tick(2);
      for (int k = 0; k < 8; k++) beat(wn[k], 2, 2);
      check("t6_new_a", dout_a, 64'h1122334455667788);
      check("t6_new_b", dout_b, 64'h8877665544332211);

      // Completion on the same edge as acceptance
      rdy = 1'b0;
      for (int k = 0; k < 8; k++) beat(8'($urandom), 1, 2);
      for (int k = 0; k < 7; k++) beat(wd[k], 1, 2);
      din = wd[7];
      en  = 1'b1;
      rdy = 1'b1;
      tick(1);
      check("t6_same_vld", vld_a, 1'b1);
      check("t6_same_dout", dout_a, 64'ha1b2c3d4e5f60718);
      check("t6_same_ovf", ovf_a, 1'b0);
      en = 1'b0;
      tick(1);
      check("t6_same_clr", vld_a, 1'b0);

      // Timeout discards a partial word
      base = tf_n[0];
      for (int k = 0; k < 3; k++) beat(8'($urandom), 2, 2);
      tick(10005);
      check("t4_tmo_n", tf_n[0] - base, 1);
      check("t4_cnt_a", bc_a, 4'd0);
      check("t4_cnt_b", bc_b, 4'd3);
      for (int k = 0; k < 8; k++) beat(we[k], 2, 2);
      check("t4_word", dout_a, 64'h0f1e2d3c4b5a6978);

      // Random traffic with random consumer stalls
      rnd_rdy = 1;
      for (int i = 0; i < 600; i++) begin
         int lo;
         lo = $urandom_range(1, 5);
         if (i % 300 == 299) lo = $urandom_range(9998, 10002);
         beat(8'($urandom), $urandom_range(1, 3), lo);
      end
      rnd_rdy = 0;
      tick(3);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
